// File: rtl/multicycle_control_if.sv
// Memory handshake bundle for the multicycle controller.
// The controller is the master and the memory is the slave.
interface multicycle_control_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output iord,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  iord,
    output mem_ack
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM; outputs decoded from current state.
// Optional MULT_STALL_EN adds a 4-cycle MULT stall state for func=011000.
module multicycle_control (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [5:0]                  opcode,
  input  logic [5:0]                  func,
  input  logic                        zero,
  multicycle_control_if.master        mem,
  output logic                        ir_we,
  output logic                        pc_we,
  output logic                        pc_src,
  output logic                        reg_we,
  output logic                        reg_dst,
  output logic                        mem_to_reg,
  output logic                        alu_src_a,
  output logic [1:0]                  alu_src_b,
  output logic [2:0]                  aop,
  output logic                        illegal,
  output logic [3:0]                  state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WB   = 4'd6,
    MEM_WR   = 4'd7,
    BRANCH   = 4'd8,
    WB_R     = 4'd9,
    WB_I     = 4'd10,
    MULT     = 4'd11
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_BEQ  = 6'b000100;

  state_e state_q, state_d;

`ifdef MULT_STALL_EN
  logic [1:0] cnt_q, cnt_d;
  logic       is_mult;
  assign is_mult = (func == 6'b011000);
`else
  logic unused_func;
  assign unused_func = ^func;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
`ifdef MULT_STALL_EN
      cnt_q   <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
`ifdef MULT_STALL_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d     = FETCH;
`ifdef MULT_STALL_EN
    cnt_d       = cnt_q;
`endif
    mem.mem_req = 1'b0;
    mem.mem_we  = 1'b0;
    mem.iord    = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_src      = 1'b0;
    reg_we      = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    aop         = 3'b000;
    illegal     = 1'b0;
    unique case (state_q)
      FETCH: begin
        mem.mem_req = 1'b1;
        alu_src_b   = 2'b01;
        aop         = 3'b110;
        state_d     = FETCH;
        if (mem.mem_ack) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        alu_src_b = 2'b11;
        aop       = 3'b110;
        unique case (opcode)
          OP_R:     state_d = EXEC_R;
          OP_LW,
          OP_SW:    state_d = MEM_ADDR;
          OP_ADDI,
          OP_SLTI,
          OP_ANDI,
          OP_ORI:   state_d = EXEC_I;
          OP_BEQ:   state_d = BRANCH;
          default: begin
            illegal = 1'b1;
            state_d = FETCH;
          end
        endcase
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        aop       = 3'b001;
        state_d   = WB_R;
`ifdef MULT_STALL_EN
        if (is_mult) begin
          state_d = MULT;
          cnt_d   = 2'd3;
        end
`endif
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = WB_I;
        unique case (opcode)
          OP_SLTI: aop = 3'b010;
          OP_ANDI: aop = 3'b011;
          OP_ORI:  aop = 3'b100;
          default: aop = 3'b110;
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        aop       = 3'b110;
        state_d   = (opcode == OP_LW) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        mem.mem_req = 1'b1;
        mem.iord    = 1'b1;
        state_d     = mem.mem_ack ? MEM_WB : MEM_RD;
      end
      MEM_WR: begin
        mem.mem_req = 1'b1;
        mem.iord    = 1'b1;
        mem.mem_we  = 1'b1;
        state_d     = mem.mem_ack ? FETCH : MEM_WR;
      end
      MEM_WB: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
      end
      WB_R: begin
        reg_we  = 1'b1;
        reg_dst = 1'b1;
      end
      WB_I: begin
        reg_we = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        aop       = 3'b101;
        pc_src    = 1'b1;
        pc_we     = zero;
      end
`ifdef MULT_STALL_EN
      MULT: begin
        alu_src_a = 1'b1;
        aop       = 3'b001;
        if (cnt_q == 2'd0) begin
          state_d = WB_R;
        end else begin
          state_d = MULT;
          cnt_d   = cnt_q - 2'd1;
        end
      end
`endif
      default: state_d = FETCH;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: add, lw, sw, beq, I-type,
// illegal opcode, mult path and asynchronous reset mid-store.
module tb_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       zero;
  logic       ir_we, pc_we, pc_src;
  logic       reg_we, reg_dst, mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] aop;
  logic       illegal;
  logic [3:0] state;

  int ncmp;
  int nfail;

  multicycle_control_if mif ();

  multicycle_control dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .func       (func),
    .zero       (zero),
    .mem        (mif.master),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .reg_we     (reg_we),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .aop        (aop),
    .illegal    (illegal),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue a fetch acknowledged on its first cycle; leaves bench in DECODE.
  task automatic fetch(input string tag);
    mif.mem_ack = 1'b1;
    #1;
    chk({tag, ":fetch_state"}, 8'(state), 8'd0);
    chk({tag, ":fetch_ir_we"}, 8'(ir_we), 8'd1);
    cyc();
    mif.mem_ack = 1'b0;
    #1;
    chk({tag, ":decode_state"}, 8'(state), 8'd1);
  endtask

  initial begin
    ncmp        = 0;
    nfail       = 0;
    rst_n       = 1'b0;
    opcode      = 6'd0;
    func        = 6'd0;
    zero        = 1'b0;
    mif.mem_ack = 1'b0;
    #3;
    chk("rst_state", 8'(state), 8'd0);
    chk("rst_mem_req", 8'(mif.mem_req), 8'd1);
    chk("rst_ir_we", 8'(ir_we), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // add
    opcode = 6'b000000;
    func   = 6'b100000;
    mif.mem_ack = 1'b1;
    #1;
    chk("add_f_pc_we", 8'(pc_we), 8'd1);
    chk("add_f_pc_src", 8'(pc_src), 8'd0);
    chk("add_f_src_b", 8'(alu_src_b), 8'd1);
    chk("add_f_aop", 8'(aop), 8'd6);
    chk("add_f_iord", 8'(mif.iord), 8'd0);
    cyc();
    mif.mem_ack = 1'b1;
    #1;
    chk("add_d_state", 8'(state), 8'd1);
    chk("add_d_src_b", 8'(alu_src_b), 8'd3);
    chk("add_d_ir_we", 8'(ir_we), 8'd0);
    cyc();
    mif.mem_ack = 1'b0;
    chk("add_x_state", 8'(state), 8'd2);
    chk("add_x_aop", 8'(aop), 8'd1);
    chk("add_x_src_a", 8'(alu_src_a), 8'd1);
    chk("add_x_reg_we", 8'(reg_we), 8'd0);
    cyc();
    chk("add_wb_state", 8'(state), 8'd9);
    chk("add_wb_reg_we", 8'(reg_we), 8'd1);
    chk("add_wb_reg_dst", 8'(reg_dst), 8'd1);
    cyc();
    chk("add_end_state", 8'(state), 8'd0);

    // lw with delayed acks
    opcode = 6'b100011;
    for (int i = 0; i < 3; i++) begin
      chk("lw_fwait_state", 8'(state), 8'd0);
      chk("lw_fwait_ir_we", 8'(ir_we), 8'd0);
      cyc();
    end
    fetch("lw");
    cyc();
    chk("lw_addr_state", 8'(state), 8'd4);
    chk("lw_addr_src_b", 8'(alu_src_b), 8'd2);
    chk("lw_addr_aop", 8'(aop), 8'd6);
    cyc();
    for (int i = 0; i < 3; i++) begin
      chk("lw_rd_state", 8'(state), 8'd5);
      chk("lw_rd_iord", 8'(mif.iord), 8'd1);
      chk("lw_rd_mem_we", 8'(mif.mem_we), 8'd0);
      chk("lw_rd_ir_we", 8'(ir_we), 8'd0);
      cyc();
    end
    mif.mem_ack = 1'b1;
    #1;
    chk("lw_rd_ack_state", 8'(state), 8'd5);
    cyc();
    chk("lw_wb_state", 8'(state), 8'd6);
    chk("lw_wb_m2r", 8'(mem_to_reg), 8'd1);
    chk("lw_wb_reg_we", 8'(reg_we), 8'd1);
    chk("lw_wb_reg_dst", 8'(reg_dst), 8'd0);
    chk("lw_wb_ack_ignored_ir", 8'(ir_we), 8'd0);
    cyc();
    mif.mem_ack = 1'b0;
    chk("lw_end_state", 8'(state), 8'd0);

    // beq taken then not taken
    opcode = 6'b000100;
    zero   = 1'b1;
    fetch("beq1");
    cyc();
    chk("beq1_state", 8'(state), 8'd8);
    chk("beq1_pc_we", 8'(pc_we), 8'd1);
    chk("beq1_pc_src", 8'(pc_src), 8'd1);
    chk("beq1_aop", 8'(aop), 8'd5);
    cyc();
    chk("beq1_end", 8'(state), 8'd0);
    zero = 1'b0;
    fetch("beq0");
    cyc();
    chk("beq0_state", 8'(state), 8'd8);
    chk("beq0_pc_we", 8'(pc_we), 8'd0);
    chk("beq0_aop", 8'(aop), 8'd5);
    cyc();
    chk("beq0_end", 8'(state), 8'd0);

    // ori and slti
    opcode = 6'b001101;
    fetch("ori");
    cyc();
    chk("ori_state", 8'(state), 8'd3);
    chk("ori_aop", 8'(aop), 8'd4);
    chk("ori_src_b", 8'(alu_src_b), 8'd2);
    cyc();
    chk("ori_wb_state", 8'(state), 8'd10);
    chk("ori_wb_reg_we", 8'(reg_we), 8'd1);
    chk("ori_wb_reg_dst", 8'(reg_dst), 8'd0);
    cyc();
    opcode = 6'b001010;
    fetch("slti");
    cyc();
    chk("slti_aop", 8'(aop), 8'd2);
    cyc();
    cyc();

    // illegal opcode
    opcode = 6'b111111;
    fetch("ill");
    chk("ill_pulse", 8'(illegal), 8'd1);
    chk("ill_reg_we", 8'(reg_we), 8'd0);
    chk("ill_mem_we", 8'(mif.mem_we), 8'd0);
    cyc();
    chk("ill_next_state", 8'(state), 8'd0);
    chk("ill_cleared", 8'(illegal), 8'd0);

    // mult
    opcode = 6'b000000;
    func   = 6'b011000;
    fetch("mul");
    cyc();
    chk("mul_exec_state", 8'(state), 8'd2);
    cyc();
`ifdef MULT_STALL_EN
    for (int i = 0; i < 4; i++) begin
      chk("mul_stall_state", 8'(state), 8'd11);
      chk("mul_stall_aop", 8'(aop), 8'd1);
      chk("mul_stall_src_a", 8'(alu_src_a), 8'd1);
      chk("mul_stall_reg_we", 8'(reg_we), 8'd0);
      cyc();
    end
`endif
    chk("mul_wb_state", 8'(state), 8'd9);
    chk("mul_wb_reg_we", 8'(reg_we), 8'd1);
    cyc();

    // sw aborted by async reset in MEM_WR
    opcode = 6'b101011;
    func   = 6'b000000;
    fetch("sw");
    cyc();
    chk("sw_addr_state", 8'(state), 8'd4);
    cyc();
    chk("sw_wr_state", 8'(state), 8'd7);
    chk("sw_wr_mem_we", 8'(mif.mem_we), 8'd1);
    chk("sw_wr_iord", 8'(mif.iord), 8'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_async_state", 8'(state), 8'd0);
    chk("rst_async_mem_we", 8'(mif.mem_we), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("rst_resume_state", 8'(state), 8'd0);
    chk("rst_resume_req", 8'(mif.mem_req), 8'd1);
    fetch("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
